// File: rtl/nes_pkg.sv
// Shared definitions for the NES gamepad reader: FSM state encoding,
// button bit positions and the serial frame length.
package nes_pkg;

  localparam int NES_BITS = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LATCH = 3'd1,
    LOW   = 3'd2,
    HIGH  = 3'd3,
    DONE  = 3'd4
  } nes_state_t;

  // Position of each button in the shifted-in frame and in `buttons`.
  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

endpackage

// File: rtl/nes_data_sync.sv
// Two-flop synchroniser for the pad's serial data line. Resets to 1, the
// level of an idle or released (active-low) pad line.
module nes_data_sync (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value; blocking here would collapse the two stages.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/nes_pad_reader.sv
// NES gamepad serial reader: latches the pad, clocks out eight bits and
// presents them as an active-high button vector. Optional NES_DEBOUNCE_EN.
module nes_pad_reader
  import nes_pkg::*;
#(
  parameter int HALF_PERIOD = 150
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                nes_data,
  output logic                nes_latch,
  output logic                nes_clk,
  output logic [NES_BITS-1:0] buttons,
  output logic                valid,
  output logic                busy
);

  localparam int CW = $clog2(2 * HALF_PERIOD);
  localparam logic [CW-1:0] LATCH_LOAD = CW'(2 * HALF_PERIOD - 1);
  localparam logic [CW-1:0] PHASE_LOAD = CW'(HALF_PERIOD - 1);
  localparam logic [2:0]    LAST_IDX   = 3'(NES_BITS - 1);

  nes_state_t          state, next_state;
  logic [CW-1:0]       cnt, next_cnt;
  logic [2:0]          idx, next_idx;
  logic [NES_BITS-1:0] shift_reg;
  logic                start_q;
  logic                sample_en;
  logic                load_buttons;
  logic                data_sync;

  nes_data_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (nes_data),
    .q     (data_sync)
  );

  // Registering the request lines the FSM and its registered outputs up so
  // that everything the pad sees starts one cycle after `start` is sampled;
  // a request seen outside IDLE (including the DONE cycle) is dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) start_q <= 1'b0;
    else       start_q <= start && (state == IDLE);
  end

  // NOTE: every signal written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    next_state   = state;
    next_cnt     = cnt;
    next_idx     = idx;
    sample_en    = 1'b0;
    load_buttons = 1'b0;
    unique case (state)
      IDLE: begin
        if (start_q) begin
          next_state = LATCH;
          next_cnt   = LATCH_LOAD;
        end
      end
      LATCH: begin
        if (cnt == '0) begin
          next_state = LOW;
          next_cnt   = PHASE_LOAD;
        end else begin
          next_cnt = cnt - 1'b1;
        end
      end
      LOW: begin
        if (cnt == '0) begin
          next_state = HIGH;
          next_cnt   = PHASE_LOAD;
          sample_en  = 1'b1;
        end else begin
          next_cnt = cnt - 1'b1;
        end
      end
      HIGH: begin
        if (cnt == '0) begin
          if (idx == LAST_IDX) begin
            next_state   = DONE;
            load_buttons = 1'b1;
          end else begin
            next_state = LOW;
            next_cnt   = PHASE_LOAD;
            next_idx   = idx + 1'b1;
          end
        end else begin
          next_cnt = cnt - 1'b1;
        end
      end
      DONE: begin
        next_state = IDLE;
        next_idx   = '0;
      end
      default: begin
        next_state = IDLE;
        next_cnt   = '0;
        next_idx   = '0;
      end
    endcase
  end

  // Outputs are registered from next_state so they coincide with the state
  // they describe; buttons is loaded on the edge entering DONE for the same
  // reason, making `valid` and the new vector appear together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      nes_latch <= 1'b0;
      nes_clk   <= 1'b0;
      valid     <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= next_state;
      cnt       <= next_cnt;
      idx       <= next_idx;
      nes_latch <= (next_state == LATCH);
      nes_clk   <= (next_state == HIGH);
      valid     <= (next_state == DONE);
      busy      <= (next_state != IDLE);
    end
  end

  // NOTE: the shift register is a handful of flops, not a memory, so it is
  // cleared on reset like the rest of the datapath.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          shift_reg      <= '0;
    else if (sample_en) shift_reg[idx] <= ~data_sync;
  end

`ifdef NES_DEBOUNCE_EN
  // A bit only changes once two consecutive polls agree on its new value.
  logic [NES_BITS-1:0] last_raw;
  logic [NES_BITS-1:0] stable;

  assign stable = ~(shift_reg ^ last_raw);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buttons  <= '0;
      last_raw <= '0;
    end else if (load_buttons) begin
      buttons  <= (shift_reg & stable) | (buttons & ~stable);
      last_raw <= shift_reg;
    end
  end
`else
  always_ff @(posedge clk or posedge reset) begin
    if (reset)             buttons <= '0;
    else if (load_buttons) buttons <= shift_reg;
  end
`endif

endmodule

// File: tb/tb_nes_pad_reader.sv
// Self-checking bench for nes_pad_reader: pad model, queue scoreboard with a
// decoupled valid-driven monitor, and cycle-exact pad waveform checks.
module tb_nes_pad_reader;

  localparam int H = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       nes_data;
  logic       nes_latch;
  logic       nes_clk;
  logic [7:0] buttons;
  logic       valid;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  nes_pad_reader #(.HALF_PERIOD(H)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .nes_data  (nes_data),
    .nes_latch (nes_latch),
    .nes_clk   (nes_clk),
    .buttons   (buttons),
    .valid     (valid),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Pad model: parallel-load on latch, shift on each clock rise, active-low line.
  logic [7:0] pad_pressed = 8'h00;
  bit         pad_connected = 1'b1;
  logic [7:0] pad_sr = 8'h00;

  always @(posedge nes_latch) pad_sr = pad_pressed;
  always @(posedge nes_clk)   pad_sr = {1'b0, pad_sr[7:1]};
  assign nes_data = pad_connected ? ~pad_sr[0] : 1'b1;

  // Reference model of the button vector and the scoreboard queue.
  logic [7:0] m_last = 8'h00;
  logic [7:0] m_buttons = 8'h00;
  logic [7:0] exp_q[$];

  task automatic model_poll(input logic [7:0] sample);
`ifdef NES_DEBOUNCE_EN
    for (int b = 0; b < 8; b++)
      if (sample[b] == m_last[b]) m_buttons[b] = sample[b];
    m_last = sample;
`else
    m_buttons = sample;
`endif
    exp_q.push_back(m_buttons);
  endtask

  // Monitor: every valid pulse must match the oldest expected vector.
  always @(negedge clk) begin
    if (valid === 1'b1) begin
      if (exp_q.size() == 0) check("unexpected_valid", {31'b0, valid}, 32'd0);
      else                   check("buttons_on_valid", {24'b0, buttons}, {24'b0, exp_q.pop_front()});
    end
  end

  // One poll with cycle-exact waveform checks relative to the sampling edge N.
  task automatic run_poll(input logic [7:0] pressed, input bit connected, input bit spam);
    int n;
    int bad_latch, bad_clk, bad_busy, bad_valid;
    bit e_latch, e_clk, e_busy, e_valid;
    bad_latch = 0; bad_clk = 0; bad_busy = 0; bad_valid = 0;
    pad_pressed   = pressed;
    pad_connected = connected;
    model_poll(connected ? pressed : 8'h00);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    n = cyc;
    for (int r = 1; r <= 18 * H + 21; r++) begin
      @(negedge clk);
      start = spam && (((r % 10 == 0) && r <= 70) || r == 18 * H + 1);
      e_latch = (r >= 1) && (r <= 2 * H);
      e_clk   = (r >= 3 * H + 1) && (r <= 18 * H) && ((((r - 3 * H - 1) / H) % 2) == 0);
      e_busy  = (r >= 1) && (r <= 18 * H + 1);
      e_valid = (r == 18 * H + 1);
      if (cyc - n != r)       bad_busy++;
      if (nes_latch !== e_latch) bad_latch++;
      if (nes_clk   !== e_clk)   bad_clk++;
      if (busy      !== e_busy)  bad_busy++;
      if (valid     !== e_valid) bad_valid++;
    end
    start = 1'b0;
    check("latch_waveform_errs", bad_latch, 0);
    check("clk_waveform_errs", bad_clk, 0);
    check("busy_waveform_errs", bad_busy, 0);
    check("valid_timing_errs", bad_valid, 0);
    check("buttons_hold", {24'b0, buttons}, {24'b0, m_buttons});
  endtask

  initial begin
    int bad;
    logic [7:0] pat;

    // Reset held with start toggling: no output activity at all.
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      start = ~start;
      if ({nes_latch, nes_clk, valid, busy, buttons} !== 12'h000) bad++;
    end
    start = 1'b0;
    check("outputs_in_reset", bad, 0);
    @(negedge clk) reset = 1'b0;
    repeat (10) @(negedge clk);
    check("idle_after_reset", {28'b0, nes_latch, nes_clk, valid, busy}, 32'd0);

    // Directed decode: A+Right pressed, then a disconnected pad.
    run_poll(8'h81, 1'b1, 1'b0);
    repeat (5) @(negedge clk);
    run_poll(8'h81, 1'b0, 1'b0);
    repeat (5) @(negedge clk);

    // Debounce sequence (also exercised without the macro).
    run_poll(8'h01, 1'b1, 1'b0);
    run_poll(8'h01, 1'b1, 1'b0);
    run_poll(8'h00, 1'b1, 1'b0);
    run_poll(8'h00, 1'b1, 1'b0);

    // Start requests during a poll and in its DONE cycle are ignored.
    run_poll(8'h5A, 1'b1, 1'b1);
    repeat (10) @(negedge clk);
    check("no_restart_after_spam", {31'b0, busy}, 32'd0);

    // Randomised polls, each pattern sent twice so debounce can settle.
    for (int i = 0; i < 8; i++) begin
      pat = 8'($urandom);
      run_poll(pat, ($urandom_range(0, 4) != 0), 1'b0);
      run_poll(pat, 1'b1, 1'b0);
      repeat ($urandom_range(0, 6)) @(negedge clk);
    end

    // Reset in the middle of a poll: outputs drop at once, no valid follows.
    pad_pressed   = 8'hFF;
    pad_connected = 1'b1;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (39) @(negedge clk);
    reset = 1'b1;
    #1;
    check("async_reset_outputs", {19'b0, nes_latch, nes_clk, valid, busy, buttons}, 32'd0);
    m_last    = 8'h00;
    m_buttons = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (100) @(negedge clk);
    check("idle_after_mid_reset", {23'b0, busy, buttons}, 32'd0);

    // Recovery poll after the aborted one.
    run_poll(8'h24, 1'b1, 1'b0);
    run_poll(8'h24, 1'b1, 1'b0);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
